// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the ROM burst fetch stage: default geometry and FSM state encoding.
package rom_burst_reader_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = 5;
    localparam int LW_DEF    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/rom_burst_reader.sv
// Burst reader in front of an asynchronous ROM: walks LEN consecutive addresses and
// presents each captured word on a valid/ready stream, one word per two cycles at best.
module rom_burst_reader
    import rom_burst_reader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int LW    = LW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [AW-1:0]    start_addr_i,
    input  logic [LW-1:0]    len_i,
    output logic [AW-1:0]    rom_addr_o,
    output logic             rom_cs_o,
    output logic             rom_oe_o,
    input  logic [WIDTH-1:0] rom_data_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [AW-1:0]    out_addr_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic             out_valid_q, out_valid_d;

    // Out-of-range lengths become a full sweep of the ROM.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rom_addr_q  <= rom_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        rom_addr_d  = rom_addr_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d = start_addr_i;
                    rem_d  = clamp_len(len_i);
                    if (clamp_len(len_i) == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        // ROM address is loaded on entry to READ so it is glitch-free there.
                        rom_addr_d = start_addr_i;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                out_data_d  = rom_data_i;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + AW'(1);
                    rem_d       = (rem_q != '0) ? rem_q - LW'(1) : '0;
                    if (rem_q <= LW'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        rom_addr_d = addr_q + AW'(1);
                        state_d    = ST_READ;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rom_addr_o  = rom_addr_q;
    assign rom_cs_o    = (state_q != ST_READ);
    assign rom_oe_o    = (state_q == ST_READ);
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_FIN);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: table of bursts plus random ones, scored against address/data arithmetic.
`timescale 1ns/1ps
module tb_rom_burst_reader;

    localparam int WIDTH = 8;
    localparam int AW    = 5;
    localparam int LW    = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    start_addr = '0;
    logic [LW-1:0]    len = '0;
    logic             out_ready = 1'b0;
    logic [AW-1:0]    rom_addr;
    logic             rom_cs, rom_oe;
    wire  [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             out_valid, busy, done;

    logic [WIDTH-1:0] mem [32];
    assign rom_data = (!rom_cs && rom_oe) ? mem[rom_addr] : 'z;

    always #5 clk = ~clk;

    rom_burst_reader #(.WIDTH(WIDTH), .AW(AW), .LW(LW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
        .len_i(len), .rom_addr_o(rom_addr), .rom_cs_o(rom_cs), .rom_oe_o(rom_oe),
        .rom_data_i(rom_data), .out_data_o(out_data), .out_addr_o(out_addr),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy), .done_o(done)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [AW-1:0]    sa;
        logic [LW-1:0]    len;
        int               rdy_mode;   // 0 always ready, 1 random, 2 five-cycle stall on word 2
        bit               pulse;      // fire a stray START mid-burst
        int               exp_n;
        logic [WIDTH-1:0] exp_first;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_count(input int l);
        return (l > 32) ? 32 : l;
    endfunction

    function automatic logic [WIDTH-1:0] model_word(input int a);
        return 8'hA0 + 8'(a % 32);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_burst(input vec_t v);
        int exp_n, got, cyc, last_hs, stall_cnt;
        bit done_seen, cs_low_seen, hold, have_rd, pulsed;
        logic [WIDTH-1:0] first_data, prev_data;
        logic [AW-1:0] last_rd, exp_a;
        exp_n = model_count(int'(v.len));
        got = 0; cyc = 0; last_hs = -10; stall_cnt = 0;
        done_seen = 0; cs_low_seen = 0; hold = 0; have_rd = 0; pulsed = 0;
        first_data = '0; prev_data = '0; last_rd = '0;
        start_addr = v.sa; len = v.len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!done_seen && cyc < 400) begin
            exp_a = AW'((int'(v.sa) + got) % 32);
            check("cs_oe_together", rom_cs, !rom_oe);
            if (!rom_cs) begin
                cs_low_seen = 1;
                check("rom_addr_in_read", rom_addr, exp_a);
                check("valid_low_in_read", out_valid, 0);
                last_rd = rom_addr; have_rd = 1;
            end else if (have_rd) begin
                check("rom_addr_hold", rom_addr, last_rd);
            end
            if (out_valid && hold) check("data_stable_stall", out_data, prev_data);
            case (v.rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && got == 1 && stall_cnt < 5) begin
                        out_ready = 1'b0; stall_cnt++;
                    end else out_ready = 1'b1;
                end
            endcase
            hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                check("out_addr", out_addr, exp_a);
                check("out_data", out_data, model_word(int'(exp_a)));
                if (got == 0) first_data = out_data;
                got++; last_hs = cyc;
            end
            if (done) begin
                done_seen = 1;
                check("done_timing", cyc, (exp_n == 0) ? 0 : last_hs + 1);
                check("valid_low_at_done", out_valid, 0);
                check("busy_at_done", busy, 1);
            end
            if (v.pulse && got == 1 && !pulsed) begin
                start = 1'b1; start_addr = v.sa + AW'(7); len = 6'd3; pulsed = 1;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("done_seen", done_seen, 1);
        check("word_count", got, v.exp_n);
        if (v.exp_n > 0) check("first_word", first_data, v.exp_first);
        else check("cs_never_low", cs_low_seen, 0);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("cs_idle", rom_cs, 1);
    endtask

    initial begin
        int got, guard;
        vec_t rv;
        for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);

        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_cs", rom_cs, 1);
        check("rst_oe", rom_oe, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_done", done, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        tbl.push_back('{sa: 5'd3,  len: 6'd4,  rdy_mode: 0, pulse: 0, exp_n: 4,  exp_first: 8'hA3});
        tbl.push_back('{sa: 5'd30, len: 6'd4,  rdy_mode: 0, pulse: 0, exp_n: 4,  exp_first: 8'hBE});
        tbl.push_back('{sa: 5'd8,  len: 6'd4,  rdy_mode: 2, pulse: 0, exp_n: 4,  exp_first: 8'hA8});
        tbl.push_back('{sa: 5'd9,  len: 6'd0,  rdy_mode: 0, pulse: 0, exp_n: 0,  exp_first: 8'h00});
        tbl.push_back('{sa: 5'd0,  len: 6'd32, rdy_mode: 0, pulse: 0, exp_n: 32, exp_first: 8'hA0});
        tbl.push_back('{sa: 5'd12, len: 6'd4,  rdy_mode: 0, pulse: 1, exp_n: 4,  exp_first: 8'hAC});
        tbl.push_back('{sa: 5'd20, len: 6'd40, rdy_mode: 1, pulse: 0, exp_n: 32, exp_first: 8'hB4});
        tbl.push_back('{sa: 5'd31, len: 6'd1,  rdy_mode: 1, pulse: 0, exp_n: 1,  exp_first: 8'hBF});
        for (int i = 0; i < 6; i++) begin
            rv.sa = AW'($urandom_range(0, 31));
            rv.len = LW'($urandom_range(0, 40));
            rv.rdy_mode = 1;
            rv.pulse = 0;
            rv.exp_n = model_count(int'(rv.len));
            rv.exp_first = model_word(int'(rv.sa));
            tbl.push_back(rv);
        end
        for (int i = 0; i < tbl.size(); i++) run_burst(tbl[i]);

        // Reset in the middle of a burst, then a fresh single-word burst.
        start_addr = 5'd5; len = 6'd8; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0; guard = 0;
        while (got < 2 && guard < 50) begin
            if (out_valid && out_ready) got++;
            guard++;
            if (got < 2) @(negedge clk);
        end
        check("midburst_words", got, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cs", rom_cs, 1);
        check("mid_rst_oe", rom_oe, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_oaddr", out_addr, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 0);
        end
        out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        rv = '{sa: 5'd10, len: 6'd1, rdy_mode: 0, pulse: 0, exp_n: 1, exp_first: 8'hAA};
        run_burst(rv);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
